gate_vec_checker: RTL and testbench

GATE_VEC_CHECKER -- requirements
Module: gate_vec_checker

---
 rtl/gate_vec_checker.sv | 119 +++++++++++
 tb/tb_gate_vec_checker.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_vec_checker.sv
// rtl/gate_vec_checker.sv - walking-ones exhaustive checker for a 2-input gate vector
module gate_vec_checker #(
    parameter int WIDTH  = 16,
    parameter int OP     = 0,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    input  logic [WIDTH-1:0] dut_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_count,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [WIDTH-1:0] LSB      = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB      = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [7:0]       SETTLE_C = 8'(SETTLE);

    logic [1:0]       state;
    logic [7:0]       cnt;
    logic [WIDTH-1:0] expected;
    logic [WIDTH-1:0] a_next;
    logic [WIDTH-1:0] b_next;
    logic             mismatch;
    logic             last_vec;

    always_comb begin
        expected = a_out | b_out;
        case (OP)
            1:       expected = a_out & b_out;
            2:       expected = a_out ^ b_out;
            3:       expected = ~(a_out | b_out);
            default: expected = a_out | b_out;
        endcase
    end

    // x/z on the response must count as a failure, hence case inequality
    assign mismatch = (dut_in !== expected);

    always_comb begin
        a_next = a_out;
        b_next = b_out >> 1;
        if (b_out == LSB) begin
            a_next = a_out << 1;
            b_next = MSB;
        end
    end

    // a_out never reaches the MSB, so that value marks the end of the sweep
    assign last_vec = (a_next == MSB);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= 8'd0;
            a_out     <= '0;
            b_out     <= '0;
            err_count <= 16'd0;
            fail_a    <= '0;
            fail_b    <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        err_count <= 16'd0;
                        fail_a    <= '0;
                        fail_b    <= '0;
                        a_out     <= LSB;
                        b_out     <= MSB;
                        cnt       <= SETTLE_C;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 8'd1;
                    if (cnt == 8'd1) begin
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (mismatch) begin
                        if (err_count != 16'hFFFF) begin
                            err_count <= err_count + 16'd1;
                        end
                        if (err_count == 16'd0) begin
                            fail_a <= a_out;
                            fail_b <= b_out;
                        end
                    end
                    if (last_vec) begin
                        state <= S_DONE;
                    end else begin
                        a_out <= a_next;
                        b_out <= b_next;
                        cnt   <= SETTLE_C;
                        state <= S_WAIT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_WAIT) || (state == S_CHECK);
    assign done = (state == S_DONE);
    assign pass = done && (err_count == 16'd0);

endmodule

// File: tb/tb_gate_vec_checker.sv
// tb/tb_gate_vec_checker.sv - randomized self-checking bench for gate_vec_checker
module tb_gate_vec_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, st0, stx;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [15:0] a0, b0, din0, err0, fa0, fb0;
    logic        busy0, done0, pass0;
    logic [15:0] a1, b1, err1, fa1, fb1;
    logic        busy1, done1, pass1;
    logic [1:0]  a2, b2, fa2, fb2;
    logic [15:0] err2;
    logic        busy2, done2, pass2;
    logic [7:0]  a3, b3, fa3, fb3;
    logic [15:0] err3;
    logic        busy3, done3, pass3;
    logic [3:0]  a4, b4, fa4, fb4;
    logic [15:0] err4;
    logic        busy4, done4, pass4;

    int          mode;
    logic [15:0] fmask;
    bit          fault_en [0:239];
    logic [15:0] e0;
    int          fidx;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];

    gate_vec_checker #(.WIDTH(16), .OP(0), .SETTLE(1)) u_dut0 (
        .clk(clk), .reset(rst), .start(st0), .a_out(a0), .b_out(b0), .dut_in(din0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .fail_a(fa0), .fail_b(fb0));
    gate_vec_checker #(.WIDTH(16), .OP(1), .SETTLE(3)) u_dut1 (
        .clk(clk), .reset(rst), .start(stx), .a_out(a1), .b_out(b1), .dut_in(a1 & b1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_a(fa1), .fail_b(fb1));
    gate_vec_checker #(.WIDTH(2), .OP(0), .SETTLE(1)) u_dut2 (
        .clk(clk), .reset(rst), .start(stx), .a_out(a2), .b_out(b2), .dut_in(a2 | b2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .fail_a(fa2), .fail_b(fb2));
    gate_vec_checker #(.WIDTH(8), .OP(2), .SETTLE(2)) u_dut3 (
        .clk(clk), .reset(rst), .start(stx), .a_out(a3), .b_out(b3), .dut_in(a3 ^ b3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3), .fail_a(fa3), .fail_b(fb3));
    gate_vec_checker #(.WIDTH(4), .OP(3), .SETTLE(1)) u_dut4 (
        .clk(clk), .reset(rst), .start(stx), .a_out(a4), .b_out(b4), .dut_in(~(a4 | b4)),
        .busy(busy4), .done(done4), .pass(pass4), .err_count(err4), .fail_a(fa4), .fail_b(fb4));

    function automatic int pos16(input logic [15:0] v);
        for (int i = 0; i < 16; i++) if (v[i]) return i;
        return 0;
    endfunction

    // Loop-back for the 16-bit OR instance: ideal, bit 0 stuck low, or random per-vector faults
    always_comb begin
        e0   = a0 | b0;
        fidx = pos16(a0) * 16 + (15 - pos16(b0));
        din0 = e0;
        if (mode == 1) din0 = e0 & 16'hFFFE;
        else if (mode == 2 && fidx < 240 && fault_en[fidx]) din0 = e0 ^ fmask;
    end

    // Reference: walk every (a,b) one-hot pair in sweep order and score the injected faults
    task automatic model0(input int m, output int errs, output logic [15:0] fa, output logic [15:0] fb);
        logic [15:0] a, b, e;
        bit bad;
        int k = 0;
        errs = 0; fa = 0; fb = 0;
        exp_q.delete();
        for (int ai = 0; ai < 15; ai++) begin
            for (int bi = 15; bi >= 0; bi--) begin
                a = 16'd1 << ai;
                b = 16'd1 << bi;
                e = a | b;
                bad = (m == 1) ? e[0] : (m == 2) ? fault_en[k] : 1'b0;
                if (bad) begin
                    if (errs == 0) begin fa = a; fb = b; end
                    errs++;
                end
                exp_q.push_back({a, b});
                k++;
            end
        end
    endtask

    task automatic run0(input int rep1, input int rep2, output int cyc);
        logic [31:0] last;
        got_q.delete();
        @(negedge clk); st0 = 1'b1;
        @(posedge clk); #1; st0 = 1'b0;
        cyc = 0; last = '0;
        while (!done0 && cyc < 2000) begin
            if (busy0 && {a0, b0} != last) begin
                got_q.push_back({a0, b0});
                last = {a0, b0};
            end
            @(posedge clk); #1; cyc++;
            st0 = (cyc == rep1 || cyc == rep2);
        end
        st0 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; st0 = 1'b0; stx = 1'b0; mode = 0; fmask = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({a0, b0, busy0, done0, pass0, err0, fa0, fb0} !== '0) begin
            n_fail++; $display("FAIL reset_state: got %h required 0", {a0, b0, busy0, done0, pass0, err0, fa0, fb0});
        end
        n_checks++;
        if ({a2, b2, busy2, done2, pass2, err2, fa2, fb2} !== '0) begin
            n_fail++; $display("FAIL reset_state_w2: got %h required 0", {a2, b2, busy2, done2, pass2, err2, fa2, fb2});
        end
        @(negedge clk); rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (busy0 !== 1'b0) begin
            n_fail++; $display("FAIL no_self_start: busy got %b required 0", busy0);
        end
    endtask

    task automatic test_reset_wins();
        @(negedge clk); rst = 1'b1; st0 = 1'b1;
        @(posedge clk); #1; rst = 1'b0; st0 = 1'b0;
        n_checks++;
        if ({busy0, a0, b0} !== '0) begin
            n_fail++; $display("FAIL reset_wins: busy,a,b got %h required 0", {busy0, a0, b0});
        end
    endtask

    task automatic test_ideal();
        int cyc, errs, mism;
        logic [15:0] fa, fb;
        mode = 0;
        model0(0, errs, fa, fb);
        run0(-1, -1, cyc);
        n_checks++;
        if (cyc !== 480) begin n_fail++; $display("FAIL ideal_latency: got %0d required 480", cyc); end
        n_checks++;
        if ({pass0, err0} !== {1'b1, 16'(errs)}) begin
            n_fail++; $display("FAIL ideal_result: pass,err got %b,%0d required 1,%0d", pass0, err0, errs);
        end
        mism = (got_q.size() == exp_q.size()) ? 0 : 1;
        foreach (exp_q[i]) if (i < got_q.size() && got_q[i] != exp_q[i]) mism++;
        n_checks++;
        if (mism !== 0 || got_q.size() !== 240) begin
            n_fail++; $display("FAIL vector_sequence: %0d vectors, %0d differ, required 240 and 0", got_q.size(), mism);
        end
        n_checks++;
        if ({busy0, a0, b0} !== {1'b0, 16'h4000, 16'h0001}) begin
            n_fail++; $display("FAIL done_hold: busy,a,b got %b,%h,%h required 0,4000,0001", busy0, a0, b0);
        end
    endtask

    task automatic test_stuck_bit();
        int cyc, errs;
        logic [15:0] fa, fb;
        mode = 1;
        model0(1, errs, fa, fb);
        run0(-1, -1, cyc);
        n_checks++;
        if ({err0, pass0, fa0, fb0} !== {16'(errs), 1'b0, fa, fb} || errs != 30) begin
            n_fail++; $display("FAIL stuck_bit0: err,pass,fa,fb got %0d,%b,%h,%h required %0d,0,%h,%h",
                                err0, pass0, fa0, fb0, errs, fa, fb);
        end
        n_checks++;
        if (cyc !== 480) begin n_fail++; $display("FAIL stuck_latency: got %0d required 480", cyc); end
    endtask

    task automatic test_random_faults();
        int cyc, errs;
        logic [15:0] fa, fb;
        for (int it = 0; it < 4; it++) begin
            for (int k = 0; k < 240; k++) fault_en[k] = ($urandom_range(0, 15) == 0);
            if (it == 3) for (int k = 0; k < 240; k++) fault_en[k] = 1'b0;
            fmask = 16'($urandom) | 16'h0001;
            mode = 2;
            model0(2, errs, fa, fb);
            run0(-1, -1, cyc);
            n_checks++;
            if ({err0, pass0, fa0, fb0} !== {16'(errs), errs == 0, fa, fb}) begin
                n_fail++; $display("FAIL random_faults[%0d]: err,pass,fa,fb got %0d,%b,%h,%h required %0d,%b,%h,%h",
                                    it, err0, pass0, fa0, fb0, errs, errs == 0, fa, fb);
            end
        end
        mode = 0;
    endtask

    task automatic test_restart_ignored();
        int cyc;
        mode = 0;
        run0(10, 200, cyc);
        n_checks++;
        if ({cyc, pass0} !== {32'd480, 1'b1}) begin
            n_fail++; $display("FAIL restart_ignored: cycles,pass got %0d,%b required 480,1", cyc, pass0);
        end
    endtask

    task automatic test_reset_midrun();
        int cyc;
        mode = 0;
        @(negedge clk); st0 = 1'b1;
        @(posedge clk); #1; st0 = 1'b0;
        repeat (99) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        n_checks++;
        if ({a0, b0, busy0, done0, pass0, err0, fa0, fb0} !== '0) begin
            n_fail++; $display("FAIL midrun_reset: got %h required 0", {a0, b0, busy0, done0, pass0, err0, fa0, fb0});
        end
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if ({busy0, a0} !== '0) begin
            n_fail++; $display("FAIL idle_after_reset: busy,a got %b,%h required 0,0", busy0, a0);
        end
        run0(-1, -1, cyc);
        n_checks++;
        if ({cyc, pass0, err0} !== {32'd480, 1'b1, 16'd0}) begin
            n_fail++; $display("FAIL rerun_after_reset: cycles,pass,err got %0d,%b,%0d required 480,1,0", cyc, pass0, err0);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        mode = 1;
        run0(-1, -1, cyc);
        mode = 0;
        run0(-1, -1, cyc);
        n_checks++;
        if ({pass0, err0, fa0, fb0} !== {1'b1, 16'd0, 16'd0, 16'd0} || cyc != 480) begin
            n_fail++; $display("FAIL back_to_back: pass,err,fa,fb,cycles got %b,%0d,%h,%h,%0d required 1,0,0,0,480",
                                pass0, err0, fa0, fb0, cyc);
        end
    endtask

    task automatic test_other_params();
        int c, d1, d2, d3, d4, h1, bad1, nv1;
        logic [31:0] prev1;
        logic [3:0]  v2_0, v2_2;
        d1 = -1; d2 = -1; d3 = -1; d4 = -1; h1 = 0; bad1 = 0; nv1 = 0; prev1 = '0;
        v2_0 = '0; v2_2 = '0;
        @(negedge clk); stx = 1'b1;
        @(posedge clk); #1; stx = 1'b0;
        c = 0;
        while (c < 2000 && (d1 < 0 || d2 < 0 || d3 < 0 || d4 < 0)) begin
            if (c == 0) v2_0 = {a2, b2};
            if (c == 2) v2_2 = {a2, b2};
            if (done1 && d1 < 0) d1 = c;
            if (done2 && d2 < 0) d2 = c;
            if (done3 && d3 < 0) d3 = c;
            if (done4 && d4 < 0) d4 = c;
            if (busy1) begin
                if (h1 == 0 || {a1, b1} == prev1) h1++;
                else begin if (h1 != 4) bad1++; nv1++; h1 = 1; end
                prev1 = {a1, b1};
            end else if (h1 != 0) begin
                if (h1 != 4) bad1++;
                nv1++; h1 = 0;
            end
            @(posedge clk); #1; c++;
        end
        n_checks++;
        if ({d1, pass1, err1} !== {32'd960, 1'b1, 16'd0}) begin
            n_fail++; $display("FAIL and_settle3: done_at,pass,err got %0d,%b,%0d required 960,1,0", d1, pass1, err1);
        end
        n_checks++;
        if (bad1 !== 0 || nv1 !== 240) begin
            n_fail++; $display("FAIL and_hold: bad holds,vectors got %0d,%0d required 0,240", bad1, nv1);
        end
        n_checks++;
        if ({v2_0, v2_2} !== 8'b0110_0101 || d2 !== 4 || pass2 !== 1'b1) begin
            n_fail++; $display("FAIL width2: vec0,vec1,done_at,pass got %b,%b,%0d,%b required 0110,0101,4,1",
                                v2_0, v2_2, d2, pass2);
        end
        n_checks++;
        if ({a2, b2} !== 4'b0101) begin
            n_fail++; $display("FAIL width2_hold: got %b required 0101", {a2, b2});
        end
        n_checks++;
        if ({d3, pass3} !== {32'd168, 1'b1}) begin
            n_fail++; $display("FAIL xor_w8: done_at,pass got %0d,%b required 168,1", d3, pass3);
        end
        n_checks++;
        if ({d4, pass4} !== {32'd24, 1'b1}) begin
            n_fail++; $display("FAIL nor_w4: done_at,pass got %0d,%b required 24,1", d4, pass4);
        end
    endtask

    initial begin
        test_reset();
        test_reset_wins();
        test_ideal();
        test_stuck_bit();
        test_random_faults();
        test_restart_ignored();
        test_reset_midrun();
        test_back_to_back();
        test_other_params();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
